// File: rtl/me_sched_pkg.sv
// rtl/me_sched_pkg.sv - shared state encoding and default sizing for the engine scheduler
package me_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        LOAD,
        PAD,
        WAIT,
        DRAIN
    } state_e;

    localparam int unsigned DEF_K         = 128;
    localparam int unsigned DEF_N         = 32;
    localparam int unsigned DEF_START_GAP = 10;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer moves away from the finished requester
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = ~done_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // A lone request always wins; the pointer only breaks ties.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/me_iddmm_sched.sv
// rtl/me_iddmm_sched.sv - two-requester scheduler feeding the shared modular-exponentiation engine
module me_iddmm_sched
    import me_sched_pkg::*;
#(
    parameter int unsigned K         = DEF_K,
    parameter int unsigned N         = DEF_N,
    parameter int unsigned START_GAP = DEF_START_GAP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    output logic [1:0]     gnt,
    input  logic [2*K-1:0] rq_x,
    input  logic [2*K-1:0] rq_y,
    input  logic [1:0]     rq_valid,
    output logic [1:0]     rq_ready,
    output logic           me_rst_n,
    output logic           me_start,
    output logic [K-1:0]   me_x,
    output logic [K-1:0]   me_y,
    output logic           me_x_valid,
    output logic           me_y_valid,
    input  logic [K-1:0]   me_result,
    input  logic           me_valid,
    output logic [K-1:0]   rsp_data,
    output logic [1:0]     rsp_valid,
    output logic           rsp_last,
    output logic           busy,
    output logic           err
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;

    state_e         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [K-1:0]   mx_q, mx_d, my_q, my_d;
    logic           mv_q, mv_d;
    logic [K-1:0]   rsp_q, rsp_d;
    logic [1:0]     rspv_q, rspv_d;
    logic           last_q, last_d;
    logic           err_q, err_d;

    logic [1:0]     arb_gnt;
    logic           g;
    logic           done;
    logic [K-1:0]   sel_x, sel_y;

    assign g     = gnt_q[1];
    assign sel_x = g ? rq_x[2*K-1:K] : rq_x[K-1:0];
    assign sel_y = g ? rq_y[2*K-1:K] : rq_y[K-1:0];

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .done_idx (g),
        .grant    (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        gap_d   = gap_q;
        mx_d    = '0;
        my_d    = '0;
        mv_d    = 1'b0;
        rsp_d   = rsp_q;
        rspv_d  = 2'b00;
        last_d  = 1'b0;
        err_d   = err_q;
        done    = 1'b0;

        // Results outside the collection window are dropped but remembered.
        if (me_valid && (state_q != WAIT) && (state_q != DRAIN)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    state_d = START;
                end
            end
            START: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == GW'(START_GAP - 1)) begin
                    wcnt_d  = '0;
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            LOAD: begin
                if (rq_valid[g]) begin
                    mx_d   = sel_x;
                    my_d   = sel_y;
                    mv_d   = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == CW'(N - 1)) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                // Zero top word; the engine expects N+1 operand words.
                mv_d    = 1'b1;
                rcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT, DRAIN: begin
                // Hold DRAIN one extra cycle so the grant stays up alongside rsp_last.
                if ((state_q == DRAIN) && (rcnt_q == CW'(N))) begin
                    done    = 1'b1;
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else if (me_valid) begin
                    rsp_d   = me_result;
                    rspv_d  = gnt_q;
                    last_d  = (rcnt_q == CW'(N - 1));
                    rcnt_d  = rcnt_q + 1'b1;
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            gap_q   <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            mv_q    <= 1'b0;
            rsp_q   <= '0;
            rspv_q  <= 2'b00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            gap_q   <= gap_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            mv_q    <= mv_d;
            rsp_q   <= rsp_d;
            rspv_q  <= rspv_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign gnt        = gnt_q;
    assign rq_ready   = (state_q == LOAD) ? gnt_q : 2'b00;
    assign me_rst_n   = !rst;
    assign me_start   = (state_q == START);
    assign me_x       = mx_q;
    assign me_y       = my_q;
    assign me_x_valid = mv_q;
    assign me_y_valid = mv_q;
    assign rsp_data   = rsp_q;
    assign rsp_valid  = rspv_q;
    assign rsp_last   = last_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule
